// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: one-burst-at-a-time arbiter between the frame FIFO
// write/read request pair and the DDR user command port.
module ddr_burst_sched #(
  parameter int MAX_WR_STREAK = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int RD_TIMEOUT    = 1023
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        ddr_init_done,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [9:0]  wr_length,
  output logic        wr_ack,
  output logic        wr_finish,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  input  logic [9:0]  rd_length,
  output logic        rd_ack,
  output logic        rd_finish,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_rw,
  output logic [24:0] mem_cmd_addr,
  output logic [9:0]  mem_cmd_len,
  input  logic        mem_wdata_ready,
  input  logic        mem_rdata_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_DATA,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  streak;
  logic [9:0]  beat;
  logic [2:0]  gap_cnt;
  logic [16:0] idle_cnt;
  logic        wr_fin_q;
  logic        rd_fin_q;

  logic wr_ok;
  logic rd_ok;
  logic grant_rd;
  logic grant_wr;
  logic streak_full;
  logic beat_last;
  logic wr_last;
  logic rd_last;
  logic rd_to;
  logic gap_done;

  // Arbitration and beat bookkeeping terms; zero-length requests count as absent.
  always_comb begin
    wr_ok       = wr_req && (wr_length != 10'd0);
    rd_ok       = rd_req && (rd_length != 10'd0);
    streak_full = (streak == 4'(MAX_WR_STREAK));
    grant_rd    = ddr_init_done && rd_ok && (streak_full || !wr_ok);
    grant_wr    = ddr_init_done && wr_ok && !grant_rd;
    beat_last   = (beat + 10'd1) == mem_cmd_len;
    wr_last     = wr_ack && beat_last;
    rd_last     = rd_ack && beat_last;
    rd_to       = (state == RD_DATA) && !mem_rdata_valid &&
                  ((idle_cnt + 17'd1) >= 17'(RD_TIMEOUT));
    gap_done    = (gap_cnt == 3'(GAP_CYCLES - 1));
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    state_nx      = state;
    mem_cmd_valid = 1'b0;
    wr_ack        = 1'b0;
    rd_ack        = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (grant_rd)      state_nx = RD_CMD;
        else if (grant_wr) state_nx = WR_CMD;
      end
      WR_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_nx = WR_DATA;
      end
      RD_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_nx = RD_DATA;
      end
      WR_DATA: begin
        wr_ack = mem_wdata_ready;
        if (mem_wdata_ready && beat_last) state_nx = GAP;
      end
      RD_DATA: begin
        rd_ack = mem_rdata_valid;
        if ((mem_rdata_valid && beat_last) || rd_to) state_nx = GAP;
      end
      GAP: begin
        if (gap_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Command latch at grant time and write-streak tracking.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      mem_cmd_addr <= '0;
      mem_cmd_len  <= '0;
      mem_cmd_rw   <= 1'b0;
      streak       <= '0;
    end else if (state == IDLE) begin
      if (grant_rd) begin
        mem_cmd_addr <= rd_addr;
        mem_cmd_len  <= rd_length;
        mem_cmd_rw   <= 1'b1;
        streak       <= '0;
      end else if (grant_wr) begin
        mem_cmd_addr <= wr_addr;
        mem_cmd_len  <= wr_length;
        mem_cmd_rw   <= 1'b0;
        if (!streak_full) streak <= streak + 4'd1;
      end
    end
  end

  // Beat, read-idle and gap counters.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      beat     <= '0;
      idle_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == IDLE)         beat <= '0;
      else if (wr_ack || rd_ack) beat <= beat + 10'd1;
      if (state == RD_CMD)       idle_cnt <= 17'd1;
      else if (state == RD_DATA) idle_cnt <= rd_ack ? 17'd1 : idle_cnt + 17'd1;
      if (state == GAP)          gap_cnt <= gap_cnt + 3'd1;
      else                       gap_cnt <= '0;
    end
  end

  // Registered finish pulses and the sticky read-timeout flag.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      wr_fin_q    <= 1'b0;
      rd_fin_q    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      wr_fin_q <= wr_last;
      rd_fin_q <= rd_last || rd_to;
      if (rd_to) timeout_err <= 1'b1;
    end
  end

  assign wr_finish = wr_fin_q;
  assign rd_finish = rd_fin_q;

endmodule

// File: tb/tb_ddr_burst_sched.sv
// tb_ddr_burst_sched: burst-level reference model with randomized
// handshakes for ddr_burst_sched.
module tb_ddr_burst_sched;

  localparam int MAX = 4;
  localparam int GAP = 2;
  localparam int TMO = 20;

  logic        clk_ref = 1'b0;
  logic        rst;
  logic        ddr_init_done;
  logic        wr_req;
  logic [24:0] wr_addr;
  logic [9:0]  wr_length;
  logic        wr_ack;
  logic        wr_finish;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic [9:0]  rd_length;
  logic        rd_ack;
  logic        rd_finish;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_rw;
  logic [24:0] mem_cmd_addr;
  logic [9:0]  mem_cmd_len;
  logic        mem_wdata_ready;
  logic        mem_rdata_valid;
  logic        busy;
  logic        timeout_err;

  ddr_burst_sched #(
    .MAX_WR_STREAK(MAX),
    .GAP_CYCLES(GAP),
    .RD_TIMEOUT(TMO)
  ) dut (
    .clk_ref(clk_ref),
    .rst(rst),
    .ddr_init_done(ddr_init_done),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_length(wr_length),
    .wr_ack(wr_ack),
    .wr_finish(wr_finish),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_length(rd_length),
    .rd_ack(rd_ack),
    .rd_finish(rd_finish),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_rw(mem_cmd_rw),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_len(mem_cmd_len),
    .mem_wdata_ready(mem_wdata_ready),
    .mem_rdata_valid(mem_rdata_valid),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_ref = ~clk_ref;

  int n_chk  = 0;
  int n_fail = 0;
  int streak_m = 0;
  bit exp_terr = 1'b0;
  bit last_rw  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule from the request view: forced read after MAX
  // writes, else write priority, else read.
  function automatic bit pick(input bit w, input bit r);
    bit rd;
    if (r && streak_m == MAX) rd = 1'b1;
    else if (w)               rd = 1'b0;
    else                      rd = 1'b1;
    if (rd) streak_m = 0;
    else if (streak_m < MAX) streak_m = streak_m + 1;
    return rd;
  endfunction

  task automatic stray();
    mem_wdata_ready = 1'($urandom);
    mem_rdata_valid = 1'($urandom);
  endtask

  // One complete burst: command handshake, data beats, finish, gap.
  task automatic do_burst(input bit rd, input logic [24:0] a,
                          input logic [9:0] l, input int stop,
                          input bit det, input bit drop, input bit kill);
    int  cyc;
    int  ccyc;
    int  beats;
    int  silent;
    int  obs;
    bit  s;
    bit  to;
    bit  acc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk_ref);
      mem_cmd_ready = 1'b0;
      stray();
      #1;
      seen = mem_cmd_valid;
      cyc++;
    end
    chk("cmd_valid", mem_cmd_valid, 1);
    if (!seen) return;
    last_rw = mem_cmd_rw;
    chk("cmd_rw", mem_cmd_rw, rd);
    chk("cmd_addr", mem_cmd_addr, a);
    chk("cmd_len", mem_cmd_len, l);
    ccyc = 1;
    acc  = 1'b0;
    while (!acc && ccyc < 40) begin
      @(negedge clk_ref);
      stray();
      mem_cmd_ready = det ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (drop) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      wr_addr = 25'($urandom);
      rd_addr = 25'($urandom);
      #1;
      chk("cmd_hold", {mem_cmd_valid, mem_cmd_rw, busy, wr_ack, rd_ack},
          {1'b1, rd, 1'b1, 1'b0, 1'b0});
      chk("cmd_fields", {mem_cmd_addr, mem_cmd_len}, {a, l});
      acc = mem_cmd_ready;
      ccyc++;
    end
    if (det) chk("cmd_cycles", ccyc, 2);
    beats  = 0;
    silent = 0;
    obs    = 0;
    to     = 1'b0;
    cyc    = 0;
    while (beats < int'(l) && !to && cyc < 2000) begin
      @(negedge clk_ref);
      mem_cmd_ready = 1'b0;
      stray();
      if (kill) ddr_init_done = 1'b0;
      if (det) s = rd ? ~cyc[0] : 1'b1;
      else     s = rd ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      if (rd && stop >= 0 && beats >= stop) s = 1'b0;
      if (rd) mem_rdata_valid = s;
      else    mem_wdata_ready = s;
      #1;
      chk("ack", rd ? rd_ack : wr_ack, s);
      chk("ack_other", rd ? wr_ack : rd_ack, 0);
      chk("data_quiet", {wr_finish, rd_finish, mem_cmd_valid, busy}, 4'b0001);
      obs = obs + int'(rd ? rd_ack : wr_ack);
      if (s) begin
        beats++;
        silent = 0;
      end else begin
        silent++;
        if (rd && silent >= TMO - 1) to = 1'b1;
      end
      cyc++;
    end
    chk("ack_count", obs, to ? stop : int'(l));
    if (to) exp_terr = 1'b1;
    @(negedge clk_ref);
    stray();
    #1;
    chk("finish", {wr_finish, rd_finish}, rd ? 2'b01 : 2'b10);
    chk("fin_misc", {wr_ack, rd_ack, mem_cmd_valid, busy}, 4'b0001);
    chk("terr", timeout_err, exp_terr);
    for (int g = 1; g < GAP; g++) begin
      @(negedge clk_ref);
      stray();
      #1;
      chk("gap", {wr_finish, rd_finish, wr_ack, rd_ack, mem_cmd_valid, busy},
          6'b000001);
    end
    @(negedge clk_ref);
    stray();
    #1;
    chk("idle", {busy, mem_cmd_valid, wr_ack, rd_ack}, 4'b0000);
  endtask

  logic [9:0] order;
  bit         r;
  bit         w;
  int         n;
  int         cyc;
  logic [9:0] wl;
  logic [9:0] rl;

  initial begin
    rst = 1'b1;
    ddr_init_done = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_length = '0;
    rd_length = '0;
    mem_cmd_ready = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    repeat (3) @(negedge clk_ref);
    #1;
    chk("rst_ctl", {wr_ack, wr_finish, rd_ack, rd_finish, mem_cmd_valid,
                    mem_cmd_rw, busy, timeout_err}, 0);
    chk("rst_cmd", {mem_cmd_addr, mem_cmd_len}, 0);
    @(negedge clk_ref);
    rst = 1'b0;

    // Requests with DDR not calibrated: nothing may be granted.
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_length = 10'd16;
    rd_length = 10'd16;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_ref);
      #1;
      chk("no_init", {mem_cmd_valid, busy}, 2'b00);
    end

    // Both requests held: four writes then a forced read, twice.
    ddr_init_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = pick(1'b1, 1'b1);
      do_burst(r, r ? rd_addr : wr_addr, 10'd16, -1, 1'b0, i == 9, 1'b0);
      order[i] = last_rw;
    end
    chk("order", order, 10'b1000010000);

    // Directed write: 0x100 x 64, command taken on its 2nd cycle.
    wr_req = 1'b1;
    wr_addr = 25'h100;
    wr_length = 10'd64;
    r = pick(1'b1, 1'b0);
    do_burst(r, 25'h100, 10'd64, -1, 1'b1, 1'b1, 1'b0);

    // Directed read of 32 with valid toggling.
    rd_req = 1'b1;
    rd_addr = 25'h1F000;
    rd_length = 10'd32;
    r = pick(1'b0, 1'b1);
    do_burst(r, 25'h1F000, 10'd32, -1, 1'b1, 1'b1, 1'b0);

    // Read of 32 whose data stops after 10 beats: timeout abort.
    rd_req = 1'b1;
    rd_addr = 25'h2A0;
    r = pick(1'b0, 1'b1);
    do_burst(r, 25'h2A0, 10'd32, 10, 1'b0, 1'b1, 1'b0);

    // Calibration lost mid write: burst completes, no new grant.
    wr_req = 1'b1;
    wr_addr = 25'h3333;
    wr_length = 10'd12;
    r = pick(1'b1, 1'b0);
    do_burst(r, 25'h3333, 10'd12, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_ref);
      #1;
      chk("init_block", {mem_cmd_valid, busy}, 2'b00);
    end
    wr_req = 1'b0;
    ddr_init_done = 1'b1;

    // Reset during the write data phase after five beats.
    wr_req = 1'b1;
    wr_addr = 25'h0ABCDE;
    wr_length = 10'd20;
    r = pick(1'b1, 1'b0);
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 60) begin
      @(negedge clk_ref);
      mem_rdata_valid = 1'($urandom);
      mem_wdata_ready = 1'b1;
      mem_cmd_ready = 1'b1;
      #1;
      if (wr_ack) n++;
      cyc++;
    end
    chk("rst_pre_beats", n, 5);
    @(negedge clk_ref);
    rst = 1'b1;
    mem_cmd_ready = 1'b0;
    #1;
    chk("rst_mid_ctl", {wr_ack, wr_finish, rd_ack, rd_finish, mem_cmd_valid,
                        mem_cmd_rw, busy, timeout_err}, 0);
    chk("rst_mid_cmd", {mem_cmd_addr, mem_cmd_len}, 0);
    streak_m = 0;
    exp_terr = 1'b0;
    wr_addr = 25'h1234;
    wr_length = 10'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ref);
      #1;
      chk("rst_no_fin", {wr_finish, busy}, 2'b00);
    end
    @(negedge clk_ref);
    rst = 1'b0;
    r = pick(1'b1, 1'b0);
    do_burst(r, 25'h1234, 10'd7, -1, 1'b0, 1'b1, 1'b0);

    // Random request mixes, including zero-length requests.
    for (int i = 0; i < 24; i++) begin
      wl = 10'($urandom_range(0, 40));
      rl = 10'($urandom_range(1, 40));
      w = 1'($urandom);
      r = (w && wl != 0) ? 1'($urandom) : 1'b1;
      wr_req = w;
      rd_req = r;
      wr_length = wl;
      rd_length = rl;
      wr_addr = 25'($urandom);
      rd_addr = 25'($urandom);
      r = pick(w && wl != 0, r);
      do_burst(r, r ? rd_addr : wr_addr, r ? rl : wl, -1, 1'b0, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_burst_sched.md
Name: ddr_burst_sched

Overview:
Single-clock burst scheduler between the frame FIFO controller's write/read request pair and the DDR user command port. Grants one burst at a time with write priority and read anti-starvation, and drives the command, address and length for the burst. Produces per-beat FIFO strobes (wr_ack/rd_ack) and end-of-burst finish pulses, which feed the FIFO controller's address counters.

Parameters:
MAX_WR_STREAK, 4, consecutive write grants allowed while rd_req pending before a read is forced (1..15)
GAP_CYCLES, 2, idle cycles after each finish pulse so registered requests can deassert (1..7)
RD_TIMEOUT, 1023, max cycles without mem_rdata_valid in a read burst before abort (1..65535)

Ports:
clk_ref  in  1  sole clock
rst  in  1  async active-high reset
ddr_init_done  in  1  DDR calibrated; no new grant while low
wr_req  in  1  level write request
wr_addr  in  25  burst start address, sampled at grant
wr_length  in  10  burst beats, sampled at grant
wr_ack  out  1  per-beat write-FIFO read strobe
wr_finish  out  1  one-cycle pulse, write burst complete
rd_req  in  1  level read request
rd_addr  in  25  burst start address, sampled at grant
rd_length  in  10  burst beats, sampled at grant
rd_ack  out  1  per-beat read-FIFO write strobe
rd_finish  out  1  one-cycle pulse, read burst complete or aborted
mem_cmd_valid  out  1  command valid; held until mem_cmd_ready
mem_cmd_ready  in  1  command accepted this cycle
mem_cmd_rw  out  1  0 write, 1 read
mem_cmd_addr  out  25  latched burst address
mem_cmd_len  out  10  latched burst length
mem_wdata_ready  in  1  controller takes one write beat this cycle
mem_rdata_valid  in  1  one read beat valid this cycle
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; set on read abort, cleared only by rst

Behaviour:
- Reset: state IDLE; all outputs 0; streak, beat and gap counters 0. Async assertion mid-burst aborts immediately with no finish pulse.
- States: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, GAP.
- IDLE arbitration (ddr_init_done=1). A request with length 0 is treated as absent.
  - rd_req and streak==MAX_WR_STREAK -> read.
  - else wr_req -> write.
  - else rd_req -> read.
- On grant (IDLE->*_CMD edge):
  - Latch addr and len into mem_cmd_addr/mem_cmd_len; set mem_cmd_rw; beat counter=0.
  - Write grant: streak increments, saturating at MAX_WR_STREAK.
  - Read grant: streak clears.
- *_CMD: mem_cmd_valid=1, with addr/len/rw stable, until mem_cmd_ready. On that cycle -> WR_DATA/RD_DATA. No valid deassert without ready.
- WR_DATA:
  - wr_ack = mem_wdata_ready, combinational in this state only; the counter increments per ack.
  - On the ack making count==len: wr_finish=1 the next cycle, state -> GAP.
- RD_DATA:
  - rd_ack = mem_rdata_valid, in this state only; the counter increments per ack.
  - On count==len: rd_finish next cycle, -> GAP.
  - Idle counter resets on each valid. If it reaches RD_TIMEOUT: timeout_err<=1, rd_finish pulse, -> GAP (partial burst).
- mem_rdata_valid or mem_wdata_ready outside the matching DATA state are ignored (ack 0).
- GAP: counts GAP_CYCLES, then -> IDLE. No grant is evaluated during GAP.
- ddr_init_done falling mid-burst: current burst completes normally. Only new grants are blocked.
- wr_req/rd_req/addr/length changes after grant have no effect on the running burst.
- Finish pulses are exactly one cycle. wr_finish and rd_finish are never high together.

Test Plan:
- wr_req=1, wr_addr=0x100, wr_length=64, mem_cmd_ready on 2nd cycle, mem_wdata_ready always 1 -> mem_cmd_valid 2 cycles with rw=0, addr 0x100, len 64; 64 wr_ack; single wr_finish; busy low after GAP.
- wr_req and rd_req both held high, all lengths 16 -> grant order W,W,W,W,R,W,W,W,W,R; streak clears on each read.
- rd_length=32, mem_rdata_valid toggling 1/0 -> exactly 32 rd_ack; rd_finish one cycle after the 32nd beat; stray valids after finish give rd_ack=0.
- Read burst len 32 with valid stopping after 10 beats, RD_TIMEOUT=20 -> 10 rd_ack; rd_finish 20 cycles after the last valid; timeout_err=1 and held across later bursts.
- ddr_init_done=0 with requests high -> no mem_cmd_valid. Drop ddr_init_done mid write burst -> burst completes, no new grant.
- Assert rst during WR_DATA beat 5 -> all outputs 0 immediately, no wr_finish. After release, a new grant re-latches fresh addr/length.
